// File: rtl/rgb_csc_packer.sv
// rtl/rgb_csc_packer.sv - YUV to RGB conversion pipeline with 3-words-per-2-pixels SRAM packer
module rgb_csc_packer #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 17,
    parameter logic [ADDR_W-1:0] RGB_BASE = 18'd146944
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  pixel_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_Y,
    input  logic [7:0]        in_U,
    input  logic [7:0]        in_V,
    output logic              wr_req,
    input  logic              wr_grant,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [2:0] {PK_EVEN, PK_W0, PK_ODD, PK_W1, PK_W2} pk_t;

    state_t             r_state;
    pk_t                r_pk;
    logic [CNT_W-1:0]   r_target, r_accepted;
    logic               r_busy, r_done;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_v1, r_v2, r_v3;
    logic signed [8:0]  r_y, r_u, r_v;
    logic signed [31:0] r_sr, r_sg, r_sb;
    logic [7:0]         r_r3, r_g3, r_b3;
    logic [7:0]         r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;

    logic               w_pk_take, w_stall, w_en2, w_en3, w_en1, w_xfer;
    logic               w_wr_done, w_finish;
    logic signed [31:0] w_y32, w_u32, w_v32;

    // Stall only when P3 holds a pixel the packer cannot take; earlier stages still fill bubbles.
    assign w_pk_take = (r_pk == PK_EVEN) || (r_pk == PK_ODD);
    assign w_stall   = r_v3 && !w_pk_take;
    assign w_en3     = !w_stall;
    assign w_en2     = !r_v2 || w_en3;
    assign w_en1     = !r_v1 || w_en2;
    assign in_ready  = (r_state == S_RUN) && (r_accepted < r_target) && !w_stall;
    assign w_xfer    = in_valid && in_ready;

    assign wr_req    = (r_pk == PK_W0) || (r_pk == PK_W1) || (r_pk == PK_W2);
    assign w_wr_done = wr_req && wr_grant;
    assign wr_addr   = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;

    // The frame ends on the grant of the last word, provided nothing is left upstream.
    assign w_finish = (r_state == S_RUN) && (r_accepted == r_target) && !r_v1 && !r_v2 && !r_v3
                      && ((r_pk == PK_EVEN) || ((r_pk == PK_W2) && wr_grant));

    assign w_y32 = $signed({{23{r_y[8]}}, r_y});
    assign w_u32 = $signed({{23{r_u[8]}}, r_u});
    assign w_v32 = $signed({{23{r_v[8]}}, r_v});

    function automatic logic [7:0] clip8(input logic signed [31:0] s);
        if (s[31])
            return 8'd0;
        else if (|s[30:24])
            return 8'hFF;
        else
            return s[23:16];
    endfunction

    always_comb begin
        wr_data = 16'h0000;
        case (r_pk)
            PK_W0:   wr_data = {r_r0, r_g0};
            PK_W1:   wr_data = {r_b0, r_r1};
            PK_W2:   wr_data = {r_g1, r_b1};
            default: wr_data = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_y  <= '0;
            r_u  <= '0;
            r_v  <= '0;
            r_sr <= '0;
            r_sg <= '0;
            r_sb <= '0;
            r_r3 <= '0;
            r_g3 <= '0;
            r_b3 <= '0;
        end else begin
            if (w_en1) begin
                r_v1 <= w_xfer;
                r_y  <= $signed({1'b0, in_Y}) - 9'sd16;
                r_u  <= $signed({1'b0, in_U}) - 9'sd128;
                r_v  <= $signed({1'b0, in_V}) - 9'sd128;
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                r_sr <= 32'sd76284 * w_y32 + 32'sd104595 * w_v32;
                r_sg <= 32'sd76284 * w_y32 - 32'sd25624 * w_u32 - 32'sd53281 * w_v32;
                r_sb <= 32'sd76284 * w_y32 + 32'sd132251 * w_u32;
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                r_r3 <= clip8(r_sr);
                r_g3 <= clip8(r_sg);
                r_b3 <= clip8(r_sb);
            end
        end
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_pk       <= PK_EVEN;
            r_target   <= '0;
            r_accepted <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= RGB_BASE;
            r_r0       <= '0;
            r_g0       <= '0;
            r_b0       <= '0;
            r_r1       <= '0;
            r_g1       <= '0;
            r_b1       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_done)
                r_addr <= r_addr + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target   <= pixel_count;
                        r_accepted <= '0;
                        r_addr     <= RGB_BASE;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer)
                        r_accepted <= r_accepted + CNT_W'(1);
                    if (w_finish) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            case (r_pk)
                PK_EVEN: if (r_v3) begin
                    r_r0 <= r_r3;
                    r_g0 <= r_g3;
                    r_b0 <= r_b3;
                    r_pk <= PK_W0;
                end
                PK_W0:   if (wr_grant) r_pk <= PK_ODD;
                PK_ODD: if (r_v3) begin
                    r_r1 <= r_r3;
                    r_g1 <= r_g3;
                    r_b1 <= r_b3;
                    r_pk <= PK_W1;
                end
                PK_W1:   if (wr_grant) r_pk <= PK_W2;
                PK_W2:   if (wr_grant) r_pk <= PK_EVEN;
                default: r_pk <= PK_EVEN;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_csc_packer.sv
// tb/tb_rgb_csc_packer.sv - randomized scoreboard bench for rgb_csc_packer
module tb_rgb_csc_packer;
    localparam logic [17:0] BASE = 18'd146944;

    logic        Clock_50 = 1'b0;
    logic        Reset, start, in_valid, wr_grant;
    logic [16:0] pixel_count;
    logic [7:0]  in_Y, in_U, in_V;
    logic        in_ready, wr_req, busy, done;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;

    rgb_csc_packer dut (
        .Clock_50(Clock_50), .Reset(Reset), .start(start), .pixel_count(pixel_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_Y(in_Y), .in_U(in_U), .in_V(in_V),
        .wr_req(wr_req), .wr_grant(wr_grant), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 Clock_50 = ~Clock_50;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference colour conversion in plain integer arithmetic.
    function automatic int clamp_chan(input int s);
        if (s < 0) return 0;
        if (s / 65536 > 255) return 255;
        return s / 65536;
    endfunction

    function automatic logic [23:0] to_rgb(input logic [23:0] yuv);
        int y, u, v, r, g, b;
        y = int'(yuv[23:16]) - 16;
        u = int'(yuv[15:8]) - 128;
        v = int'(yuv[7:0]) - 128;
        r = clamp_chan(76284 * y + 104595 * v);
        g = clamp_chan(76284 * y - 25624 * u - 53281 * v);
        b = clamp_chan(76284 * y + 132251 * u);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    logic [23:0] src_q[$];
    logic [15:0] exp_words[$];
    logic [15:0] got_words[$];
    logic [23:0] even_pix;
    int          n_acc, granted, cyc, first_xfer_cyc, first_wreq_cyc, last_grant_cyc, done_cyc;
    bit          done_seen, mon_en, prev_hold;
    logic [17:0] hold_addr;
    logic [15:0] hold_data;

    initial cyc = 0;

    always @(negedge Clock_50) begin
        cyc++;
        if (mon_en && !Reset) begin
            if (prev_hold) begin
                check("hold_req", 32'(wr_req), 32'd1);
                check("hold_addr", 32'(wr_addr), 32'(hold_addr));
                check("hold_data", 32'(wr_data), 32'(hold_data));
            end
            prev_hold = wr_req && !wr_grant;
            hold_addr = wr_addr;
            hold_data = wr_data;
            if (in_valid && in_ready) begin
                logic [23:0] p;
                p = to_rgb({in_Y, in_U, in_V});
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                if (n_acc % 2 == 0) begin
                    even_pix = p;
                    exp_words.push_back(p[23:8]);
                end else begin
                    exp_words.push_back({even_pix[7:0], p[23:16]});
                    exp_words.push_back(p[15:0]);
                end
                n_acc++;
            end
            if (wr_req && first_wreq_cyc < 0) first_wreq_cyc = cyc;
            if (wr_req && wr_grant) begin
                got_words.push_back(wr_data);
                if (exp_words.size() == 0)
                    check("extra_word", 32'(wr_data), 32'hFFFF_FFFF);
                else
                    check("word", 32'(wr_data), 32'(exp_words.pop_front()));
                check("addr", 32'(wr_addr), 32'(BASE) + 32'(granted));
                granted++;
                last_grant_cyc = cyc;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic init_frame();
        exp_words.delete();
        got_words.delete();
        n_acc = 0;
        granted = 0;
        first_xfer_cyc = -1;
        first_wreq_cyc = -1;
        last_grant_cyc = 0;
        done_cyc = 0;
        done_seen = 1'b0;
        prev_hold = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic fill_random(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(24'($urandom));
    endtask

    // Runs one frame from src_q; sb pulses start mid-frame, bp holds grant low, abort resets after that many words.
    task automatic run_frame(input int vpct, input int gpct, input bit bp, input bit sb, input int abort);
        int n, idx, c, bp_cnt;
        n = src_q.size();
        idx = 0;
        bp_cnt = bp ? 10 : 0;
        init_frame();
        pixel_count = 17'(n);
        start = 1'b1;
        @(posedge Clock_50); #1;
        start = 1'b0;
        check("busy_run", 32'(busy), 32'd1);
        for (c = 0; c < 3000 && !done_seen; c++) begin
            if (abort > 0 && granted >= abort) break;
            start       = sb && (c == 20);
            pixel_count = (sb && c == 20) ? 17'd2 : 17'(n);
            in_valid = (idx < n) && ($urandom_range(99) < vpct);
            if (idx < n) {in_Y, in_U, in_V} = src_q[idx];
            if (bp_cnt > 0 && first_wreq_cyc >= 0) begin
                wr_grant = 1'b0;
                bp_cnt--;
                if (bp_cnt == 6) check("bp_ready", 32'(in_ready), 32'd0);
            end else begin
                wr_grant = ($urandom_range(99) < gpct);
            end
            @(negedge Clock_50);
            if (in_valid && in_ready) idx++;
            @(posedge Clock_50); #1;
        end
        in_valid = 1'b0;
        wr_grant = 1'b0;
        start    = 1'b0;
        if (abort > 0) begin
            #2 Reset = 1'b1;
            #1;
            mon_en = 1'b0;
            check("rst_wr_req", 32'(wr_req), 32'd0);
            check("rst_wr_data", 32'(wr_data), 32'd0);
            check("rst_wr_addr", 32'(wr_addr), 32'(BASE));
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            repeat (2) @(posedge Clock_50);
            #1 Reset = 1'b0;
            repeat (3) begin
                @(negedge Clock_50);
                check("rst_no_done", 32'(done), 32'd0);
                check("rst_idle_busy", 32'(busy), 32'd0);
            end
            @(posedge Clock_50); #1;
        end else begin
            check("done_seen", 32'(done_seen), 32'd1);
            check("done_lat", 32'(done_cyc - last_grant_cyc), 32'd1);
            check("word_count", 32'(granted), 32'(3 * n / 2));
            check("first_req_lat", 32'(first_wreq_cyc - first_xfer_cyc), 32'd4);
            check("busy_after", 32'(busy), 32'd0);
            check("exp_left", 32'(exp_words.size()), 32'd0);
        end
    endtask

    initial begin
        Reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        wr_grant = 1'b0;
        pixel_count = '0;
        {in_Y, in_U, in_V} = '0;
        mon_en = 1'b0;
        #1 Reset = 1'b1;
        repeat (3) @(posedge Clock_50);
        #1;
        check("reset_wr_req", 32'(wr_req), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'(BASE));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        Reset = 1'b0;
        @(posedge Clock_50); #1;

        src_q = '{24'h108080, 24'h808080};
        run_frame(100, 100, 1'b0, 1'b0, 0);
        check("bg_w0", 32'(got_words[0]), 32'h0000);
        check("bg_w1", 32'(got_words[1]), 32'h0082);
        check("bg_w2", 32'(got_words[2]), 32'h8282);

        src_q = '{24'hFF8080, 24'h1080FF, 24'hEB8080, 24'hEB8080};
        run_frame(100, 100, 1'b0, 1'b0, 0);
        check("clip_w0", 32'(got_words[0]), 32'hFFFF);
        check("clip_w1", 32'(got_words[1]), 32'hFFCA);
        check("clip_w2", 32'(got_words[2]), 32'h0000);
        check("clip_w3", 32'(got_words[3]), 32'hFEFE);
        check("clip_w5", 32'(got_words[5]), 32'hFEFE);

        fill_random(8);
        run_frame(100, 100, 1'b0, 1'b0, 0);

        fill_random(16);
        run_frame(100, 100, 1'b1, 1'b0, 0);

        fill_random(12);
        run_frame(70, 70, 1'b0, 1'b1, 0);

        fill_random(16);
        run_frame(100, 100, 1'b0, 1'b0, 5);

        fill_random(6);
        run_frame(80, 80, 1'b0, 1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            fill_random(2 * int'($urandom_range(1, 20)));
            run_frame(int'($urandom_range(50, 100)), int'($urandom_range(40, 100)), 1'b0, 1'b0, 0);
        end

        begin
            logic [17:0] idle_addr;
            idle_addr = wr_addr;
            wr_grant = 1'b1;
            repeat (5) @(posedge Clock_50);
            #1;
            check("idle_grant_addr", 32'(wr_addr), 32'(idle_addr));
            check("idle_grant_req", 32'(wr_req), 32'd0);
            wr_grant = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
